// File: rtl/crypto_arb_pkg.sv
// Shared types for the two-requester crypto arbiter: FSM states and requester index.
package crypto_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // Requester 0 is the RAS spill/fill engine, requester 1 the MMIO crypto client.
  typedef logic req_idx_t;

endpackage

// File: rtl/crypto_arbiter_if.sv
// Request/response bundle between the two requesters, the arbiter and the cipher core.
interface crypto_arbiter_if
  import crypto_arb_pkg::*;
#(
  parameter int W = 32
);

  logic           r0_valid;
  logic           r0_mode;
  logic [2*W-1:0] r0_pt;
  logic           r0_ready;
  logic           r0_rvalid;
  logic [2*W-1:0] r0_ct;
  logic           r0_rready;

  logic           r1_valid;
  logic           r1_mode;
  logic [2*W-1:0] r1_pt;
  logic           r1_ready;
  logic           r1_rvalid;
  logic [2*W-1:0] r1_ct;
  logic           r1_rready;

  logic           c_valid;
  logic           c_mode;
  logic [2*W-1:0] c_pt;
  logic           c_ready;
  logic           c_rvalid;
  logic [2*W-1:0] c_ct;
  logic           c_rready;

  logic           busy;
  req_idx_t       owner;

  // Arbiter view.
  modport slave (
    input  r0_valid, r0_mode, r0_pt, r0_rready,
    input  r1_valid, r1_mode, r1_pt, r1_rready,
    input  c_ready, c_rvalid, c_ct,
    output r0_ready, r0_rvalid, r0_ct,
    output r1_ready, r1_rvalid, r1_ct,
    output c_valid, c_mode, c_pt, c_rready,
    output busy, owner
  );

  // Environment view: requesters plus cipher core.
  modport master (
    output r0_valid, r0_mode, r0_pt, r0_rready,
    output r1_valid, r1_mode, r1_pt, r1_rready,
    output c_ready, c_rvalid, c_ct,
    input  r0_ready, r0_rvalid, r0_ct,
    input  r1_ready, r1_rvalid, r1_ct,
    input  c_valid, c_mode, c_pt, c_rready,
    input  busy, owner
  );

endinterface

// File: rtl/crypto_arb_pick.sv
// Combinational winner select for two requesters.
// CRYPTO_ARB_RR_EN: ties go to the requester that was not the last owner; otherwise requester 0 wins ties.
module crypto_arb_pick
  import crypto_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  req_idx_t           last_owner,
  output logic               grant,
  output req_idx_t           index
);

  assign grant = |valid;

`ifdef CRYPTO_ARB_RR_EN
  always_comb begin
    if (&valid) begin
      index = ~last_owner;
    end else begin
      index = valid[1];
    end
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
  assign index             = ~valid[0];
`endif

endmodule

// File: rtl/crypto_arbiter.sv
// Two-requester arbiter in front of a single block-cipher core, one operation in flight.
// CRYPTO_ARB_RR_EN selects round-robin tie-breaking in crypto_arb_pick (fixed priority otherwise).
module crypto_arbiter
  import crypto_arb_pkg::*;
#(
  parameter int W = 32
) (
  input logic             clk,
  input logic             arst_n,
  crypto_arbiter_if.slave bus
);

  localparam int BW = 2 * W;

  arb_state_t          state_q, state_d;
  req_idx_t            owner_q, owner_d;
  req_idx_t            rr_last_q, rr_last_d;
  logic                mode_q, mode_d;
  logic [BW-1:0]       pt_q, pt_d;
  logic [BW-1:0]       ct_q, ct_d;

  logic [NUM_REQ-1:0]  valid_v;
  logic [NUM_REQ-1:0]  mode_v;
  logic [NUM_REQ-1:0]  rready_v;
  logic [NUM_REQ-1:0]  ready_v;
  logic [NUM_REQ-1:0]  rvalid_v;
  logic [BW-1:0]       pt_v [NUM_REQ];

  logic                grant;
  req_idx_t            pick_idx;

  assign valid_v  = {bus.r1_valid, bus.r0_valid};
  assign mode_v   = {bus.r1_mode, bus.r0_mode};
  assign rready_v = {bus.r1_rready, bus.r0_rready};
  assign pt_v[0]  = bus.r0_pt;
  assign pt_v[1]  = bus.r1_pt;

  crypto_arb_pick u_pick (
    .valid      (valid_v),
    .last_owner (rr_last_q),
    .grant      (grant),
    .index      (pick_idx)
  );

  // ready is gated by arst_n so every output reads 0 while reset is held.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign ready_v[gi]  = arst_n && (state_q == ST_IDLE) && grant
                          && (pick_idx == req_idx_t'(gi));
    assign rvalid_v[gi] = (state_q == ST_RESP) && (owner_q == req_idx_t'(gi));
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    mode_d    = mode_q;
    pt_d      = pt_q;
    ct_d      = ct_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d   = ST_ISSUE;
          owner_d   = pick_idx;
          rr_last_d = pick_idx;
          mode_d    = mode_v[pick_idx];
          pt_d      = pt_v[pick_idx];
        end
      end
      ST_ISSUE: begin
        if (bus.c_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.c_rvalid) begin
          ct_d    = bus.c_ct;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rready_v[owner_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // rr_last resets to 1 so the first tie after reset goes to requester 0.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      mode_q    <= 1'b0;
      pt_q      <= '0;
      ct_q      <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      mode_q    <= mode_d;
      pt_q      <= pt_d;
      ct_q      <= ct_d;
    end
  end

  assign bus.r0_ready  = ready_v[0];
  assign bus.r1_ready  = ready_v[1];
  assign bus.r0_rvalid = rvalid_v[0];
  assign bus.r1_rvalid = rvalid_v[1];
  assign bus.r0_ct     = ct_q;
  assign bus.r1_ct     = ct_q;

  assign bus.c_valid   = (state_q == ST_ISSUE);
  assign bus.c_mode    = mode_q;
  assign bus.c_pt      = pt_q;
  assign bus.c_rready  = (state_q == ST_WAIT);

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_crypto_arbiter.sv
// Self-checking bench for crypto_arbiter: transaction-level model, directed scenarios, random traffic.
module tb_crypto_arbiter;
  import crypto_arb_pkg::*;

  localparam int W  = 32;
  localparam int BW = 2 * W;
`ifdef CRYPTO_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk    = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  crypto_arbiter_if #(.W(W)) bus ();

  crypto_arbiter #(.W(W)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: phase 0 idle, 1 core issue, 2 core wait, 3 response pending.
  int            m_phase = 0;
  int            m_last  = -1;
  bit            m_owner = 1'b0;
  bit            m_mode  = 1'b0;
  logic [BW-1:0] m_pt    = '0;
  logic [BW-1:0] m_ct    = '0;

  function automatic int pick_winner(input bit v0, input bit v1, input int last);
    if (v0 && v1) return (RR && last == 0) ? 1 : 0;
    return v0 ? 0 : 1;
  endfunction

  always @(negedge clk) begin
    logic [8:0] act_ctl;
    logic [8:0] exp_ctl;
    bit         any;
    int         w;
    act_ctl = {bus.busy, bus.owner, bus.c_valid, bus.c_rready, bus.r0_ready,
               bus.r1_ready, bus.r0_rvalid, bus.r1_rvalid, bus.c_mode};
    if (!arst_n) begin
      check("reset_ctl", BW'(act_ctl), '0);
      check("reset_c_pt", bus.c_pt, '0);
      check("reset_r0_ct", bus.r0_ct, '0);
      check("reset_r1_ct", bus.r1_ct, '0);
      m_phase = 0;
      m_last  = -1;
      m_owner = 1'b0;
      m_mode  = 1'b0;
      m_pt    = '0;
      m_ct    = '0;
    end else begin
      any = bus.r0_valid | bus.r1_valid;
      w   = pick_winner(bus.r0_valid, bus.r1_valid, m_last);
      exp_ctl = {m_phase != 0, m_owner, m_phase == 1, m_phase == 2,
                 m_phase == 0 && any && w == 0, m_phase == 0 && any && w == 1,
                 m_phase == 3 && !m_owner, m_phase == 3 && m_owner, m_mode};
      check("ctl", BW'(act_ctl), BW'(exp_ctl));
      check("c_pt", bus.c_pt, m_pt);
      check("r0_ct", bus.r0_ct, m_ct);
      check("r1_ct", bus.r1_ct, m_ct);
      case (m_phase)
        0: if (any) begin
          m_owner = (w == 1);
          m_last  = w;
          m_mode  = (w == 1) ? bus.r1_mode : bus.r0_mode;
          m_pt    = (w == 1) ? bus.r1_pt : bus.r0_pt;
          m_phase = 1;
        end
        1: if (bus.c_ready) m_phase = 2;
        2: if (bus.c_rvalid) begin
          m_ct    = bus.c_ct;
          m_phase = 3;
        end
        default: if (m_owner ? bus.r1_rready : bus.r0_rready) m_phase = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int n, input bit mode, input logic [BW-1:0] pt, output bit ok);
    ok = 1'b0;
    if (n == 0) begin
      bus.r0_valid = 1'b1; bus.r0_mode = mode; bus.r0_pt = pt;
    end else begin
      bus.r1_valid = 1'b1; bus.r1_mode = mode; bus.r1_pt = pt;
    end
    for (int i = 0; i < 30 && !ok; i++) begin
      #1;
      ok = (n == 0) ? bus.r0_ready : bus.r1_ready;
      tick();
    end
    if (n == 0) bus.r0_valid = 1'b0;
    else        bus.r1_valid = 1'b0;
    check("accept", BW'(ok), BW'(1));
  endtask

  task automatic drain();
    bit idle_seen;
    idle_seen = 1'b0;
    bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
    bus.c_ready = 1'b1; bus.c_rvalid = 1'b1; bus.c_ct = 64'h5A5A_0F0F_3C3C_9696;
    bus.r0_rready = 1'b1; bus.r1_rready = 1'b1;
    for (int i = 0; i < 20 && !idle_seen; i++) begin
      tick();
      #1;
      idle_seen = !bus.busy;
    end
    bus.c_ready = 1'b0; bus.c_rvalid = 1'b0;
    bus.r0_rready = 1'b0; bus.r1_rready = 1'b0;
    check("drain_idle", BW'(idle_seen), BW'(1));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 arst_n = 1'b0;
    @(posedge clk);
    #3 arst_n = 1'b1;
    tick();
  endtask

  initial begin
    bit            ok;
    int            nacc;
    int            owners [3];
    int            exp_own [3];
    bit            acc0;
    bit            acc1;
    bit            do_rst;

    bus.r0_valid = 0; bus.r0_mode = 0; bus.r0_pt = '0; bus.r0_rready = 0;
    bus.r1_valid = 0; bus.r1_mode = 0; bus.r1_pt = '0; bus.r1_rready = 0;
    bus.c_ready = 0; bus.c_rvalid = 0; bus.c_ct = '0;
    repeat (2) @(posedge clk);
    #3 arst_n = 1'b1;
    tick();
    #1;
    check("post_reset_busy", BW'(bus.busy), '0);
    check("post_reset_owner", BW'(bus.owner), '0);
    check("post_reset_ct", bus.r0_ct, '0);

    // Single encrypt from requester 0, core answers a couple of cycles later.
    bus.c_ready = 1'b1;
    accept(0, 1'b0, 64'h1, ok);
    #1;
    check("t029_c_valid", BW'(bus.c_valid), BW'(1));
    check("t029_c_pt", bus.c_pt, 64'h1);
    tick();
    bus.c_ready = 1'b0;
    tick();
    tick();
    bus.c_rvalid = 1'b1; bus.c_ct = 64'hA5;
    #1;
    check("t029_c_rready", BW'(bus.c_rready), BW'(1));
    tick();
    bus.c_rvalid = 1'b0;
    #1;
    check("t029_r0_rvalid", BW'(bus.r0_rvalid), BW'(1));
    check("t029_r0_ct", bus.r0_ct, 64'hA5);
    check("t029_r1_rvalid", BW'(bus.r1_rvalid), '0);
    bus.r0_rready = 1'b1;
    tick();
    bus.r0_rready = 1'b0;
    #1;
    check("t029_idle", BW'(bus.busy), '0);

    // Three back-to-back ties.
    do_reset();
    owners = '{9, 9, 9};
    exp_own = RR ? '{0, 1, 0} : '{0, 0, 0};
    nacc = 0;
    bus.r0_valid = 1'b1; bus.r0_mode = 1'b0; bus.r0_pt = 64'h100;
    bus.r1_valid = 1'b1; bus.r1_mode = 1'b1; bus.r1_pt = 64'h200;
    bus.c_ready = 1'b1; bus.c_rvalid = 1'b1; bus.c_ct = 64'h3030;
    bus.r0_rready = 1'b1; bus.r1_rready = 1'b1;
    for (int cyc = 0; cyc < 60 && nacc < 3; cyc++) begin
      #1;
      if (bus.r0_ready || bus.r1_ready) begin
        owners[nacc] = bus.r1_ready ? 1 : 0;
        nacc++;
      end
      tick();
    end
    bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
    drain();
    check("t030_rounds", BW'(nacc), BW'(3));
    for (int i = 0; i < 3; i++) check($sformatf("t030_owner%0d", i), BW'(owners[i]), BW'(exp_own[i]));

    // Requester 1 stalls the response; requester 0 must not be served meanwhile.
    accept(1, 1'b0, 64'h1111_2222_3333_4444, ok);
    bus.r0_valid = 1'b1; bus.r0_mode = 1'b0; bus.r0_pt = 64'h7;
    bus.c_ready = 1'b1; bus.c_rvalid = 1'b1; bus.c_ct = 64'hC0FFEE;
    tick();
    tick();
    bus.c_ready = 1'b0; bus.c_rvalid = 1'b0; bus.c_ct = 64'hBAD;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t031_r1_rvalid", BW'(bus.r1_rvalid), BW'(1));
      check("t031_r1_ct", bus.r1_ct, 64'hC0FFEE);
      check("t031_r0_ready", BW'(bus.r0_ready), '0);
      tick();
    end
    bus.r1_rready = 1'b1;
    tick();
    bus.r1_rready = 1'b0;
    #1;
    check("t031_r0_ready_after", BW'(bus.r0_ready), BW'(1));
    tick();
    bus.r0_valid = 1'b0;
    drain();

    // Reset asserted while waiting on the core.
    bus.c_ready = 1'b1;
    accept(0, 1'b1, 64'hDEAD, ok);
    tick();
    bus.c_ready = 1'b0;
    #1 arst_n = 1'b0;
    #1;
    check("t032_ctl", BW'({bus.busy, bus.owner, bus.c_valid, bus.c_rready, bus.c_mode,
                           bus.r0_rvalid, bus.r1_rvalid}), '0);
    check("t032_c_pt", bus.c_pt, '0);
    check("t032_ct", bus.r0_ct, '0);
    @(posedge clk);
    #3 arst_n = 1'b1;
    bus.c_rvalid = 1'b1; bus.c_ct = 64'hEEEE;
    bus.r0_rready = 1'b1; bus.r1_rready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      #1;
      check("t032_no_resp", BW'({bus.r0_rvalid, bus.r1_rvalid, bus.busy}), '0);
    end
    bus.c_rvalid = 1'b0; bus.r0_rready = 1'b0; bus.r1_rready = 1'b0;
    tick();

    // Stray core response during ISSUE is ignored.
    accept(0, 1'b0, 64'h33, ok);
    bus.c_rvalid = 1'b1; bus.c_ct = 64'hBAD0;
    #1;
    check("t033_c_valid", BW'(bus.c_valid), BW'(1));
    check("t033_c_rready", BW'(bus.c_rready), '0);
    tick();
    bus.c_rvalid = 1'b0;
    #1;
    check("t033_still_issue", BW'(bus.c_valid), BW'(1));
    bus.c_ready = 1'b1;
    tick();
    bus.c_ready = 1'b0;
    #1;
    check("t033_wait", BW'({bus.c_valid, bus.c_rready}), BW'(2'b01));
    drain();

    // Decrypt from requester 1 keeps the latched payload.
    accept(1, 1'b1, 64'h0123_4567_89AB_CDEF, ok);
    bus.r1_pt = 64'hFFFF_FFFF_FFFF_FFFF; bus.r1_mode = 1'b0;
    #1;
    check("t034_c_mode", BW'(bus.c_mode), BW'(1));
    check("t034_c_pt", bus.c_pt, 64'h0123_4567_89AB_CDEF);
    tick();
    check("t034_c_pt_hold", bus.c_pt, 64'h0123_4567_89AB_CDEF);
    drain();

    // Random traffic against the model.
    acc0 = 1'b0;
    acc1 = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!bus.r0_valid || acc0) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.r0_valid = 1'b1; bus.r0_mode = 1'($urandom_range(0, 1)); bus.r0_pt = {$urandom, $urandom};
        end else begin
          bus.r0_valid = 1'b0;
          if ($urandom_range(0, 1) == 0) bus.r0_pt = {$urandom, $urandom};
        end
      end
      if (!bus.r1_valid || acc1) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.r1_valid = 1'b1; bus.r1_mode = 1'($urandom_range(0, 1)); bus.r1_pt = {$urandom, $urandom};
        end else begin
          bus.r1_valid = 1'b0;
          if ($urandom_range(0, 1) == 0) bus.r1_pt = {$urandom, $urandom};
        end
      end
      bus.c_ready   = ($urandom_range(0, 2) == 0);
      bus.c_rvalid  = ($urandom_range(0, 3) == 0);
      bus.c_ct      = {$urandom, $urandom};
      bus.r0_rready = ($urandom_range(0, 3) != 0);
      bus.r1_rready = ($urandom_range(0, 3) != 0);
      do_rst = ($urandom_range(0, 249) == 0);
      if (do_rst) begin
        #1 arst_n = 1'b0;
        #2;
      end else begin
        #3;
      end
      acc0 = bus.r0_ready;
      acc1 = bus.r1_ready;
      @(posedge clk);
      #1;
      if (do_rst) #2 arst_n = 1'b1;
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crypto_arbiter.md
CRYPTO_ARBITER -- requirements
Module: crypto_arbiter

Interface
REQ-001 SHALL have parameter W, default 32, meaning block-cipher word width; the core block is 2*W.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port arst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have, for n in {0,1}, ports rn_valid input 1, rn_mode input 1 (0 encrypt, 1 decrypt), rn_pt input 2W, and rn_ready output 1 as the request channel.
REQ-005 SHALL have, for n in {0,1}, ports rn_rvalid output 1, rn_ct output 2W, and rn_rready input 1 as the response channel.
REQ-006 SHALL have core-side ports c_valid output 1, c_mode output 1, c_pt output 2W, c_ready input 1, c_rvalid input 1, c_ct input 2W, and c_rready output 1.
REQ-007 SHALL have ports busy output 1 (state not IDLE) and owner output 1 (index of the current or last granted requester).
REQ-008 SHALL treat requester 0 as the RAS spill/fill engine and requester 1 as the MMIO crypto client.

Function
REQ-009 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, with one operation in flight.
REQ-010 IDLE: SHALL pick a winner among asserted rn_valid, assert the winner's rn_ready for exactly that cycle, latch rn_mode/rn_pt and owner, and go to ISSUE.
REQ-011 IDLE: SHALL go to ISSUE in the cycle after acceptance, with no idle bubble beyond that.
REQ-012 IDLE with no rn_valid: SHALL stay in IDLE with both rn_ready low.
REQ-013 rn_ready SHALL never be asserted outside IDLE, and never to both requesters in the same cycle.
REQ-014 ISSUE: SHALL drive c_valid=1 with the latched c_mode/c_pt; on c_ready=1, SHALL go to WAIT with c_valid low in the next cycle.
REQ-015 WAIT: on c_rvalid=1, SHALL assert c_rready in the same cycle, capture c_ct into a 2W register, and go to RESP.
REQ-016 c_rready SHALL be 0 in every state other than WAIT; c_rvalid outside WAIT SHALL be ignored.
REQ-017 RESP: SHALL hold r[owner]_rvalid=1 with the captured word until r[owner]_rready=1, then go to IDLE in the next cycle.
REQ-018 RESP: a requester that never asserts rready SHALL stall the arbiter indefinitely; there is no timeout.
REQ-019 rn_ct SHALL show the captured word for both n; only the owner's rvalid SHALL be asserted.
REQ-020 Minimum accept-to-response latency SHALL be 3 cycles plus the core latency.
REQ-021 Requesters SHALL hold valid and payload until ready; the arbiter samples them only in the accept cycle.

Reset
REQ-022 On arst_n=0, SHALL immediately enter IDLE, including during an operation in progress; any in-flight result is discarded.
REQ-023 On arst_n=0, SHALL clear all outputs, the latched payload/ct registers, and owner to 0.
REQ-024 SHALL emit no response for a request that was cut off by reset.

Configuration
REQ-025 With CRYPTO_ARB_RR_EN defined, ties SHALL be granted to the requester that is not the last owner (round-robin).
REQ-026 With CRYPTO_ARB_RR_EN undefined, ties SHALL always be granted to requester 0 (fixed priority).

Structure
REQ-027 Package crypto_arb_pkg SHALL hold the FSM state enum and the requester-index typedef.
REQ-028 The winner select SHALL be a sub-module crypto_arb_pick: combinational, inputs valid[1:0] and last_owner, outputs grant and index, with the CRYPTO_ARB_RR_EN logic inside it.

Verification
REQ-029 r0 encrypt, pt=64'h1, core responds 2 cycles after c_ready, ct=64'hA5 -> r0_rvalid with ct 64'hA5; r1_rvalid stays 0.
REQ-030 r0 and r1 valid in the same cycle, three back-to-back rounds -> with RR: owners 0,1,0; fixed: owners 0,0,0.
REQ-031 r1_rready held low for 10 cycles in RESP -> r1_rvalid held and ct stable; r0_ready stays 0 throughout.
REQ-032 arst_n pulsed low during WAIT -> busy=0 and all outputs 0 asynchronously; no rvalid afterwards.
REQ-033 c_rvalid pulsed while in ISSUE -> c_rready=0 and the pulse is ignored; state advances only after c_ready.
REQ-034 r1 decrypt request -> c_mode=1 during ISSUE; c_pt equals the latched r1_pt even if r1_pt changes after acceptance.
